// File: rtl/mavg_stream_checker.sv
// Self-checking sink for a moving-average filter: rebuilds the expected average from the input
// stream and compares it with the filter output. Define MAVG_CHK_STOP_ON_ERR_EN to stop at the first mismatch.
module mavg_stream_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LOG2_WINDOW = 2,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned NUM_CHECKS  = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             start,
    input  logic             smp_valid,
    input  logic [WIDTH-1:0] smp_data,
    input  logic [WIDTH-1:0] dut_out,
    output logic             err_pulse,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             done,
    output logic             pass
);
    localparam int unsigned N  = 1 << LOG2_WINDOW;
    localparam int unsigned SW = WIDTH + LOG2_WINDOW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                        state_q, state_d;
    logic [N-1:0][WIDTH-1:0]       hist_q, hist_d;
    logic signed [SW-1:0]          sum_q, sum_d;
    logic [LATENCY-1:0]            dl_vld_q, dl_vld_d;
    logic [LATENCY-1:0][WIDTH-1:0] dl_exp_q, dl_exp_d;
    logic                          err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]              mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0]              check_cnt_q, check_cnt_d;
    logic [CNT_W-1:0]              first_err_idx_q, first_err_idx_d;
    logic                          done_q, done_d;
    logic                          pass_q, pass_d;

    logic                 accept, compare, mismatch, last;
    logic signed [SW-1:0] smp_ext, old_ext;

    // Window history and running sum; the expected average enters the delay line head.
    always_comb begin
        accept  = (state_q == StRun) && smp_valid;
        smp_ext = {{(SW - WIDTH){smp_data[WIDTH-1]}}, smp_data};
        old_ext = {{(SW - WIDTH){hist_q[N-1][WIDTH-1]}}, hist_q[N-1]};
        hist_d  = hist_q;
        sum_d   = sum_q;
        if (accept) begin
            sum_d     = sum_q + smp_ext - old_ext;
            hist_d[0] = smp_data;
            for (int unsigned i = 1; i < N; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
        dl_vld_d    = dl_vld_q;
        dl_exp_d    = dl_exp_q;
        dl_vld_d[0] = accept;
        dl_exp_d[0] = WIDTH'(sum_d >>> LOG2_WINDOW);
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_exp_d[i] = dl_exp_q[i-1];
        end
    end

    always_comb begin
        compare         = (state_q == StRun) && dl_vld_q[LATENCY-1];
        mismatch        = compare && (dut_out != dl_exp_q[LATENCY-1]);
        err_pulse_d     = 1'b0;
        mismatch_cnt_d  = mismatch_cnt_q;
        check_cnt_d     = check_cnt_q;
        first_err_idx_d = first_err_idx_q;
        if (compare) begin
            check_cnt_d = check_cnt_q + CNT_W'(1);
            if (mismatch) begin
                err_pulse_d = 1'b1;
                if (mismatch_cnt_q != '1) begin
                    mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
                end
                if (mismatch_cnt_q == '0) begin
                    first_err_idx_d = check_cnt_q;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        pass_d  = pass_q;
        last    = compare && (check_cnt_d == CNT_W'(NUM_CHECKS));
`ifdef MAVG_CHK_STOP_ON_ERR_EN
        last    = last || mismatch;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = (mismatch_cnt_d == '0);
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q         <= StIdle;
            hist_q          <= '0;
            sum_q           <= '0;
            dl_vld_q        <= '0;
            dl_exp_q        <= '0;
            err_pulse_q     <= 1'b0;
            mismatch_cnt_q  <= '0;
            check_cnt_q     <= '0;
            first_err_idx_q <= '0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            hist_q          <= hist_d;
            sum_q           <= sum_d;
            dl_vld_q        <= dl_vld_d;
            dl_exp_q        <= dl_exp_d;
            err_pulse_q     <= err_pulse_d;
            mismatch_cnt_q  <= mismatch_cnt_d;
            check_cnt_q     <= check_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
        end
    end

    assign err_pulse     = err_pulse_q;
    assign mismatch_cnt  = mismatch_cnt_q;
    assign check_cnt     = check_cnt_q;
    assign first_err_idx = first_err_idx_q;
    assign done          = done_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_mavg_stream_checker.sv
// Testbench for mavg_stream_checker: directed scenarios plus randomized streams against a
// queue-based window-average model.
`timescale 1ns/1ps
module tb_mavg_stream_checker;
    localparam int WIDTH       = 8;
    localparam int LOG2_WINDOW = 2;
    localparam int LATENCY     = 1;
    localparam int NUM_CHECKS  = 16;
    localparam int CNT_W       = 16;
    localparam int N           = 1 << LOG2_WINDOW;
`ifdef MAVG_CHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    logic             system1000 = 1'b0;
    logic             system1000_rst;
    logic             start;
    logic             smp_valid;
    logic [WIDTH-1:0] smp_data;
    logic [WIDTH-1:0] dut_out;
    logic             err_pulse;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] check_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic             done;
    logic             pass;

    mavg_stream_checker #(
        .WIDTH      (WIDTH),
        .LOG2_WINDOW(LOG2_WINDOW),
        .LATENCY    (LATENCY),
        .NUM_CHECKS (NUM_CHECKS),
        .CNT_W      (CNT_W)
    ) u_dut (
        .system1000    (system1000),
        .system1000_rst(system1000_rst),
        .start         (start),
        .smp_valid     (smp_valid),
        .smp_data      (smp_data),
        .dut_out       (dut_out),
        .err_pulse     (err_pulse),
        .mismatch_cnt  (mismatch_cnt),
        .check_cnt     (check_cnt),
        .first_err_idx (first_err_idx),
        .done          (done),
        .pass          (pass)
    );

    always #5 system1000 = ~system1000;

    // Reference model: 0 idle, 1 run, 2 done; window kept newest-first.
    int m_state;
    int m_hist[$];
    int pend_due[$];
    int pend_exp[$];
    int ecount;
    int m_check, m_mis, m_first;
    bit m_done, m_pass, m_err;
    int n_vec, n_err;

    function automatic int floor_div(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_hist.delete();
        for (int i = 0; i < N; i++) m_hist.push_back(0);
        pend_due.delete();
        pend_exp.delete();
        m_check = 0;
        m_mis   = 0;
        m_first = 0;
        m_done  = 1'b0;
        m_pass  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, return at the falling edge.
    // Unless forced, dut_out carries the model's expected value when a compare is due.
    task automatic cycle(input bit rst, input bit st, input bit v, input int d,
                         input bit force_dut, input int dv);
        bit         have, mism;
        int         gold, drv, sum, s_state;
        logic [7:0] g8, d8;
        have = (pend_due.size() > 0) && (pend_due[0] == ecount);
        gold = have ? pend_exp[0] : 0;
        drv  = force_dut ? dv : (have ? gold : int'($urandom_range(255)));
        system1000_rst = rst;
        start          = st;
        smp_valid      = v;
        smp_data       = 8'(d);
        dut_out        = 8'(drv);
        @(posedge system1000);
        m_err = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            s_state = m_state;
            if (have) begin
                void'(pend_due.pop_front());
                void'(pend_exp.pop_front());
                if (s_state == 1) begin
                    g8   = 8'(gold);
                    d8   = 8'(drv);
                    mism = (g8 != d8);
                    if (mism) begin
                        m_err = 1'b1;
                        if (m_mis == 0) m_first = m_check;
                        if (m_mis < 65535) m_mis++;
                    end
                    m_check++;
                    if (m_check == NUM_CHECKS || (STOP_ON_ERR && mism)) begin
                        m_state = 2;
                        m_done  = 1'b1;
                        m_pass  = (m_mis == 0);
                    end
                end
            end
            if (s_state == 1 && v) begin
                m_hist.push_front(d);
                void'(m_hist.pop_back());
                sum = 0;
                foreach (m_hist[i]) sum += m_hist[i];
                pend_due.push_back(ecount + LATENCY);
                pend_exp.push_back(floor_div(sum, N));
            end
            if (s_state == 0 && st) m_state = 1;
        end
        ecount++;
        @(negedge system1000);
    endtask

    function automatic int rnd_smp();
        return int'($urandom_range(200)) - 100;
    endfunction

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 55, 1, 3);
        n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL reset_err_pulse: got %0b want 0", err_pulse); end
        n_vec++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL reset_mismatch_cnt: got %0d want 0", mismatch_cnt); end
        n_vec++; if (check_cnt !== 16'd0) begin n_err++; $display("FAIL reset_check_cnt: got %0d want 0", check_cnt); end
        n_vec++; if (first_err_idx !== 16'd0) begin n_err++; $display("FAIL reset_first_err_idx: got %0d want 0", first_err_idx); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %0b want 0", pass); end
    endtask

    // Idle sample and start-coincident sample must both be ignored, so 4s average to 1,2,3,4,4.
    task automatic test_constant();
        int dut_tbl[5] = '{1, 2, 3, 4, 4};
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 100, 1, 0);
        cycle(0, 1, 1, 100, 1, 0);
        for (int j = 0; j < 6; j++) begin
            cycle(0, 0, j < 5, 4, 1, (j == 0) ? 0 : dut_tbl[j-1]);
            n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL const_err_pulse[%0d]: got %0b want 0", j, err_pulse); end
        end
        n_vec++; if (check_cnt !== 16'd5) begin n_err++; $display("FAIL const_check_cnt: got %0d want 5", check_cnt); end
        n_vec++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL const_mismatch_cnt: got %0d want 0", mismatch_cnt); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL const_done: got %0b want 0", done); end
    endtask

    task automatic test_negative();
        int smp_tbl[5] = '{-3, 0, 0, 0, 0};
        int dut_tbl[5] = '{-1, -1, -1, -1, 0};
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 0);
        for (int j = 0; j < 6; j++) begin
            cycle(0, 0, j < 5, (j < 5) ? smp_tbl[j] : 0, 1, (j == 0) ? 0 : dut_tbl[j-1]);
            n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL neg_err_pulse[%0d]: got %0b want 0", j, err_pulse); end
        end
        n_vec++; if (check_cnt !== 16'd5) begin n_err++; $display("FAIL neg_check_cnt: got %0d want 5", check_cnt); end
        n_vec++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL neg_mismatch_cnt: got %0d want 0", mismatch_cnt); end
    endtask

    // Check 6 is corrupted; wrong outputs keep arriving after done but must be ignored.
    task automatic test_error();
        int npulse = 0;
        int exp_cnt;
        exp_cnt = STOP_ON_ERR ? 6 : NUM_CHECKS;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int j = 0; j < NUM_CHECKS + 5; j++) begin
            cycle(0, 0, 1'b1, rnd_smp(), (j == 6) || (j > NUM_CHECKS), 127);
            if (err_pulse === 1'b1) npulse++;
            n_vec++; if (err_pulse !== m_err) begin n_err++; $display("FAIL err_err_pulse[%0d]: got %0b want %0b", j, err_pulse, m_err); end
        end
        n_vec++; if (npulse != 1) begin n_err++; $display("FAIL err_pulse_count: got %0d want 1", npulse); end
        n_vec++; if (mismatch_cnt !== 16'd1) begin n_err++; $display("FAIL err_mismatch_cnt: got %0d want 1", mismatch_cnt); end
        n_vec++; if (first_err_idx !== 16'd5) begin n_err++; $display("FAIL err_first_err_idx: got %0d want 5", first_err_idx); end
        n_vec++; if (check_cnt !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL err_check_cnt: got %0d want %0d", check_cnt, exp_cnt); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL err_done: got %0b want 1", done); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL err_pass: got %0b want 0", pass); end
    endtask

    task automatic test_bubbles();
        bit vld_tbl[6] = '{1, 0, 0, 1, 1, 0};
        int cnt_tbl[6] = '{0, 1, 1, 1, 2, 3};
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) begin
            cycle(0, 0, vld_tbl[j], rnd_smp(), 0, 0);
            n_vec++; if (check_cnt !== CNT_W'(cnt_tbl[j])) begin n_err++; $display("FAIL bubble_check_cnt[%0d]: got %0d want %0d", j, check_cnt, cnt_tbl[j]); end
            n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL bubble_err_pulse[%0d]: got %0b want 0", j, err_pulse); end
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, rnd_smp(), 0, 0);
        cycle(1, 0, 0, 0, 1, 127);
        n_vec++; if (check_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_check_cnt: got %0d want 0", check_cnt); end
        n_vec++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_mismatch_cnt: got %0d want 0", mismatch_cnt); end
        n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL mid_rst_err_pulse: got %0b want 0", err_pulse); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %0b want 0", done); end
        cycle(0, 0, 0, 0, 1, 127);
        n_vec++; if (check_cnt !== 16'd0) begin n_err++; $display("FAIL post_rst_check_cnt: got %0d want 0", check_cnt); end
        n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL post_rst_err_pulse: got %0b want 0", err_pulse); end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, rnd_smp(), 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        n_vec++; if (check_cnt !== 16'd1) begin n_err++; $display("FAIL restart_check_cnt: got %0d want 1", check_cnt); end
        n_vec++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL restart_mismatch_cnt: got %0d want 0", mismatch_cnt); end
    endtask

    task automatic test_random(input int corrupt_pct);
        bit st, v, cor;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int j = 0; j < 60; j++) begin
            st  = ($urandom_range(9) == 0);
            v   = ($urandom_range(9) < 7);
            cor = (int'($urandom_range(99)) < corrupt_pct);
            cycle(0, st, v, int'($urandom_range(255)) - 128, cor, int'($urandom_range(255)));
            n_vec++; if (err_pulse !== m_err) begin n_err++; $display("FAIL rnd_err_pulse[%0d]: got %0b want %0b", j, err_pulse, m_err); end
            n_vec++; if (mismatch_cnt !== CNT_W'(m_mis)) begin n_err++; $display("FAIL rnd_mismatch_cnt[%0d]: got %0d want %0d", j, mismatch_cnt, m_mis); end
            n_vec++; if (check_cnt !== CNT_W'(m_check)) begin n_err++; $display("FAIL rnd_check_cnt[%0d]: got %0d want %0d", j, check_cnt, m_check); end
            n_vec++; if (first_err_idx !== CNT_W'(m_first)) begin n_err++; $display("FAIL rnd_first_err_idx[%0d]: got %0d want %0d", j, first_err_idx, m_first); end
            n_vec++; if (done !== m_done) begin n_err++; $display("FAIL rnd_done[%0d]: got %0b want %0b", j, done, m_done); end
            n_vec++; if (pass !== m_pass) begin n_err++; $display("FAIL rnd_pass[%0d]: got %0b want %0b", j, pass, m_pass); end
        end
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        ecount         = 0;
        system1000_rst = 1'b1;
        start          = 1'b0;
        smp_valid      = 1'b0;
        smp_data       = '0;
        dut_out        = '0;
        model_reset();
        test_reset();
        test_constant();
        test_negative();
        test_error();
        test_bubbles();
        test_reset_midrun();
        test_random(0);
        test_random(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
